// File: rtl/id_i_buf.sv
// Instruction-decode input buffer: decodes each incoming word at enqueue and queues the decoded fields in a FIFO.
// Optional feature: define ID_I_BUF_CP0_EN to decode the COP0 opcode (MFC0/MTC0/TLBWI/TLBP/ERET/WAIT).

package id_i_buf_pkg;
  typedef enum logic [7:0] {
    INST_INVALID = 8'd0,
    INST_BEQ     = 8'd1,
    INST_BNE     = 8'd2,
    INST_BLEZ    = 8'd3,
    INST_BGTZ    = 8'd4,
    INST_ADDI    = 8'd5,
    INST_ADDIU   = 8'd6,
    INST_SLTI    = 8'd7,
    INST_SLTIU   = 8'd8,
    INST_ANDI    = 8'd9,
    INST_ORI     = 8'd10,
    INST_XORI    = 8'd11,
    INST_LUI     = 8'd12,
    INST_LB      = 8'd13,
    INST_LH      = 8'd14,
    INST_LWL     = 8'd15,
    INST_LW      = 8'd16,
    INST_LBU     = 8'd17,
    INST_LHU     = 8'd18,
    INST_LWR     = 8'd19,
    INST_SB      = 8'd20,
    INST_SH      = 8'd21,
    INST_SWL     = 8'd22,
    INST_SW      = 8'd23,
    INST_SWR     = 8'd24,
    INST_BLTZ    = 8'd25,
    INST_BGEZ    = 8'd26,
    INST_BLTZAL  = 8'd27,
    INST_BGEZAL  = 8'd28,
    INST_MFC0    = 8'd29,
    INST_MTC0    = 8'd30,
    INST_TLBWI   = 8'd31,
    INST_TLBP    = 8'd32,
    INST_ERET    = 8'd33,
    INST_WAIT    = 8'd34
  } inst_e;
endpackage

module id_i_buf
  import id_i_buf_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int IMM_W = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [31:0]              in_code,
  input  logic [31:0]              in_pc,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [7:0]               out_inst,
  output logic [4:0]               out_reg_s,
  output logic [4:0]               out_reg_t,
  output logic [IMM_W-1:0]         out_imm,
  output logic [31:0]              out_pc,
  output logic                     out_is_branch,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic [1:0] {IMM_SEXT, IMM_ZEXT, IMM_LUI, IMM_BR} imm_kind_e;

  typedef struct packed {
    logic [7:0]       inst;
    logic [4:0]       rs;
    logic [4:0]       rt;
    logic [IMM_W-1:0] imm;
    logic [31:0]      pc;
    logic             br;
  } entry_t;

  entry_t          mem [DEPTH];
  entry_t          dec;
  entry_t          head;
  inst_e           dec_inst;
  imm_kind_e       imm_kind;
  logic [AW-1:0]   wr_ptr, rd_ptr;
  logic            push, pop;
  logic [5:0]      opcode;
  logic [4:0]      rs, rt;
  logic [15:0]     imm16;
  logic [IMM_W-1:0] imm_sext;

  assign opcode   = in_code[31:26];
  assign rs       = in_code[25:21];
  assign rt       = in_code[20:16];
  assign imm16    = in_code[15:0];
  assign imm_sext = IMM_W'($signed(imm16));

  always_comb begin
    dec_inst = INST_INVALID;
    imm_kind = IMM_SEXT;
    unique case (opcode)
      6'h01: begin
        imm_kind = IMM_BR;
        case (rt)
          5'h00:   dec_inst = INST_BLTZ;
          5'h01:   dec_inst = INST_BGEZ;
          5'h10:   dec_inst = INST_BLTZAL;
          5'h11:   dec_inst = INST_BGEZAL;
          default: dec_inst = INST_INVALID;
        endcase
      end
      6'h04: begin dec_inst = INST_BEQ;  imm_kind = IMM_BR;   end
      6'h05: begin dec_inst = INST_BNE;  imm_kind = IMM_BR;   end
      6'h06: begin dec_inst = INST_BLEZ; imm_kind = IMM_BR;   end
      6'h07: begin dec_inst = INST_BGTZ; imm_kind = IMM_BR;   end
      6'h08: dec_inst = INST_ADDI;
      6'h09: dec_inst = INST_ADDIU;
      6'h0a: dec_inst = INST_SLTI;
      6'h0b: dec_inst = INST_SLTIU;
      6'h0c: begin dec_inst = INST_ANDI; imm_kind = IMM_ZEXT; end
      6'h0d: begin dec_inst = INST_ORI;  imm_kind = IMM_ZEXT; end
      6'h0e: begin dec_inst = INST_XORI; imm_kind = IMM_ZEXT; end
      6'h0f: begin dec_inst = INST_LUI;  imm_kind = IMM_LUI;  end
`ifdef ID_I_BUF_CP0_EN
      6'h10: begin
        if (rs == 5'd0)      dec_inst = INST_MFC0;
        else if (rs == 5'd4) dec_inst = INST_MTC0;
        else if (in_code[25]) begin
          case (in_code[5:0])
            6'h02:   dec_inst = INST_TLBWI;
            6'h08:   dec_inst = INST_TLBP;
            6'h18:   dec_inst = INST_ERET;
            6'h20:   dec_inst = INST_WAIT;
            default: dec_inst = INST_INVALID;
          endcase
        end
      end
`endif
      6'h20: dec_inst = INST_LB;
      6'h21: dec_inst = INST_LH;
      6'h22: dec_inst = INST_LWL;
      6'h23: dec_inst = INST_LW;
      6'h24: dec_inst = INST_LBU;
      6'h25: dec_inst = INST_LHU;
      6'h26: dec_inst = INST_LWR;
      6'h28: dec_inst = INST_SB;
      6'h29: dec_inst = INST_SH;
      6'h2a: dec_inst = INST_SWL;
      6'h2b: dec_inst = INST_SW;
      6'h2e: dec_inst = INST_SWR;
      default: dec_inst = INST_INVALID;
    endcase
  end

  always_comb begin
    dec      = '0;
    dec.inst = dec_inst;
    dec.rs   = rs;
    dec.rt   = rt;
    dec.pc   = in_pc;
    dec.br   = (imm_kind == IMM_BR) && (dec_inst != INST_INVALID);
    unique case (imm_kind)
      IMM_ZEXT: dec.imm = IMM_W'(imm16);
      // truncates to zero when IMM_W is 16
      IMM_LUI:  dec.imm = IMM_W'({imm16, 16'h0000});
      IMM_BR:   dec.imm = imm_sext << 2;
      default:  dec.imm = imm_sext;
    endcase
  end

  assign out_valid = (count != '0);
  assign in_ready  = !rst && !flush && (count < CW'(DEPTH));
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready && !flush;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      unique case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= dec;
  end

  assign head          = mem[rd_ptr];
  assign out_inst      = out_valid ? head.inst : '0;
  assign out_reg_s     = out_valid ? head.rs   : '0;
  assign out_reg_t     = out_valid ? head.rt   : '0;
  assign out_imm       = out_valid ? head.imm  : '0;
  assign out_pc        = out_valid ? head.pc   : '0;
  assign out_is_branch = out_valid ? head.br   : 1'b0;

endmodule

// File: tb/tb_id_i_buf.sv
// Directed self-checking bench for id_i_buf (DEPTH=4, IMM_W=32); honours ID_I_BUF_CP0_EN for the ERET vector.

module tb_id_i_buf;
  import id_i_buf_pkg::*;

  logic        clk = 1'b0;
  logic        rst, flush, in_valid, in_ready, out_valid, out_ready, out_is_branch;
  logic [31:0] in_code, in_pc, out_imm, out_pc;
  logic [7:0]  out_inst;
  logic [4:0]  out_reg_s, out_reg_t;
  logic [2:0]  count;
  int          total = 0;
  int          bad   = 0;

  id_i_buf #(.DEPTH(4), .IMM_W(32)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_code(in_code), .in_pc(in_pc),
    .out_valid(out_valid), .out_ready(out_ready), .out_inst(out_inst),
    .out_reg_s(out_reg_s), .out_reg_t(out_reg_t), .out_imm(out_imm),
    .out_pc(out_pc), .out_is_branch(out_is_branch), .count(count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [31:0] code, input logic [31:0] pc);
    in_valid = 1'b1;
    in_code  = code;
    in_pc    = pc;
  endtask

  logic [31:0] fill_code [5];
  logic [7:0]  fill_inst [4];
  logic [4:0]  fill_rs   [4];
  logic [31:0] fill_imm  [4];

  initial begin
    fill_code[0] = 32'h8C220010; fill_inst[0] = INST_LW;   fill_rs[0] = 5'd1; fill_imm[0] = 32'h00000010;
    fill_code[1] = 32'hA0A3FFF0; fill_inst[1] = INST_SB;   fill_rs[1] = 5'd5; fill_imm[1] = 32'hFFFFFFF0;
    fill_code[2] = 32'h30A4F00F; fill_inst[2] = INST_ANDI; fill_rs[2] = 5'd5; fill_imm[2] = 32'h0000F00F;
    fill_code[3] = 32'h28C5FFFF; fill_inst[3] = INST_SLTI; fill_rs[3] = 5'd6; fill_imm[3] = 32'hFFFFFFFF;
    fill_code[4] = 32'h20000001;

    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_code = '0; in_pc = '0;
    #3;
    check("rst_out_valid", out_valid, 0);
    check("rst_in_ready", in_ready, 0);
    check("rst_count", count, 0);
    step(); step();
    rst = 1'b0;
    #1;
    check("rel_in_ready", in_ready, 1);

    // single ORI, no bypass on empty queue
    drive(32'h3421FFFF, 32'h100);
    #1;
    check("nobypass_valid", out_valid, 0);
    step();
    in_valid = 1'b0;
    check("ori_valid", out_valid, 1);
    check("ori_inst", out_inst, INST_ORI);
    check("ori_rs", out_reg_s, 1);
    check("ori_rt", out_reg_t, 1);
    check("ori_imm", out_imm, 32'h0000FFFF);
    check("ori_pc", out_pc, 32'h100);
    check("ori_br", out_is_branch, 0);
    step();
    check("ori_hold_imm", out_imm, 32'h0000FFFF);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    check("ori_pop_valid", out_valid, 0);
    check("ori_pop_zero", out_inst, 0);
    check("ori_pop_pc", out_pc, 0);

    // back-to-back stream with simultaneous push/pop
    out_ready = 1'b1;
    drive(32'h2402FFFC, 32'h200);
    step();
    check("addiu_inst", out_inst, INST_ADDIU);
    check("addiu_rt", out_reg_t, 2);
    check("addiu_imm", out_imm, 32'hFFFFFFFC);
    drive(32'h3C011234, 32'h204);
    step();
    check("lui_inst", out_inst, INST_LUI);
    check("lui_imm", out_imm, 32'h12340000);
    check("lui_count", count, 1);
    drive(32'h1000FFFF, 32'h208);
    step();
    in_valid = 1'b0;
    check("beq_inst", out_inst, INST_BEQ);
    check("beq_imm", out_imm, 32'hFFFFFFFC);
    check("beq_br", out_is_branch, 1);
    check("beq_pc", out_pc, 32'h208);
    step();
    check("stream_empty", out_valid, 0);

    // fill to DEPTH, fifth word refused
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      drive(fill_code[i], 32'h300 + 32'(i * 4));
      #1;
      check($sformatf("fill_ready%0d", i), in_ready, (i < 4) ? 1 : 0);
      step();
    end
    check("full_count", count, 4);
    out_ready = 1'b1;
    #1;
    check("full_pop_ready", in_ready, 0);
    in_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      check($sformatf("drain_inst%0d", i), out_inst, fill_inst[i]);
      check($sformatf("drain_rs%0d", i), out_reg_s, fill_rs[i]);
      check($sformatf("drain_imm%0d", i), out_imm, fill_imm[i]);
      check($sformatf("drain_pc%0d", i), out_pc, 32'h300 + 32'(i * 4));
      step();
    end
    check("drain_empty", out_valid, 0);
    check("drain_count", count, 0);

    // flush drops queue, same-cycle pop and same-cycle push
    out_ready = 1'b0;
    drive(32'h04110003, 32'h400);
    step();
    check("bgezal_inst", out_inst, INST_BGEZAL);
    check("bgezal_imm", out_imm, 32'h0000000C);
    check("bgezal_br", out_is_branch, 1);
    flush = 1'b1; out_ready = 1'b1;
    drive(32'h3421FFFF, 32'h404);
    #1;
    check("flush_ready", in_ready, 0);
    step();
    flush = 1'b0; in_valid = 1'b0;
    check("flush_count", count, 0);
    check("flush_valid", out_valid, 0);
    step();
    check("flush_dropped", out_valid, 0);

    // COP0 and unknown opcodes
    out_ready = 1'b0;
    drive(32'h42000018, 32'h500);
    step();
    in_valid = 1'b0;
`ifdef ID_I_BUF_CP0_EN
    check("eret_inst", out_inst, INST_ERET);
`else
    check("eret_inst", out_inst, INST_INVALID);
`endif
    check("eret_valid", out_valid, 1);
    out_ready = 1'b1;
    drive(32'hFC000000, 32'h504);
    step();
    in_valid = 1'b0;
    check("fc_inst", out_inst, INST_INVALID);
    check("fc_pc", out_pc, 32'h504);
    step();
    check("cp0_empty", out_valid, 0);

    // asynchronous reset with entries queued
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      drive(fill_code[i], 32'h600);
      step();
    end
    in_valid = 1'b0;
    check("pre_rst_count", count, 3);
    #2;
    rst = 1'b1;
    #1;
    check("async_valid", out_valid, 0);
    check("async_count", count, 0);
    check("async_ready", in_ready, 0);
    step();
    rst = 1'b0;
    #1;
    check("post_rst_count", count, 0);
    check("post_rst_ready", in_ready, 1);
    check("post_rst_valid", out_valid, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/id_i_buf.md
ID_I_BUF -- requirements
Module: id_i_buf

Interface
- REQ-001 SHALL have parameter DEPTH, default 4, FIFO entry count; power of two, 2..16.
- REQ-002 SHALL have parameter IMM_W, default 32, width of the extended immediate output; range 16..64.
- REQ-003 SHALL have port clk  input  1  sole clock; all state updates on its rising edge.
- REQ-004 SHALL have port rst  input  1  asynchronous, active-high reset.
- REQ-005 SHALL have port flush  input  1  synchronous clear of all queued entries.
- REQ-006 SHALL have port in_valid  input  1  upstream instruction word present.
- REQ-007 SHALL have port in_ready  output  1  block accepts a word this cycle.
- REQ-008 SHALL have port in_code  input  32  raw instruction word.
- REQ-009 SHALL have port in_pc  input  32  address of in_code.
- REQ-010 SHALL have port out_valid  output  1  head entry present.
- REQ-011 SHALL have port out_ready  input  1  downstream consumes head.
- REQ-012 SHALL have port out_inst  output  8  decoded INST_* code from the shared defs header.
- REQ-013 SHALL have ports out_reg_s, out_reg_t  output  5 each  in_code[25:21], in_code[20:16].
- REQ-014 SHALL have port out_imm  output  IMM_W  extended immediate.
- REQ-015 SHALL have port out_pc  output  32  pc of head entry.
- REQ-016 SHALL have port out_is_branch  output  1  head is BEQ/BNE/BLEZ/BGTZ/BLTZ/BGEZ/BLTZAL/BGEZAL.
- REQ-017 SHALL have port count  output  $clog2(DEPTH)+1  number of valid entries.

Function
- REQ-018 SHALL decode in_code combinationally at enqueue and store decoded fields, not the raw word.
- REQ-019 SHALL decode opcode 0x01 by rt: 0x00 BLTZ, 0x01 BGEZ, 0x10 BLTZAL, 0x11 BGEZAL, else INST_INVALID.
- REQ-020 SHALL decode opcodes 0x04-0x0f to BEQ,BNE,BLEZ,BGTZ,ADDI,ADDIU,SLTI,SLTIU,ANDI,ORI,XORI,LUI in order.
- REQ-021 SHALL decode 0x20-0x26 to LB,LH,LWL,LW,LBU,LHU,LWR and 0x28,0x29,0x2a,0x2b,0x2e to SB,SH,SWL,SW,SWR; every other opcode INST_INVALID.
- REQ-022 SHALL form out_imm: ANDI/ORI/XORI zero-extended; LUI = imm16<<16 zero-extended (IMM_W=16: 0); branches sign-extended then <<2, truncated to IMM_W; all others sign-extended.
- REQ-023 SHALL push when in_valid && in_ready, pop when out_valid && out_ready; in_ready = (count < DEPTH) && !flush.
- REQ-024 SHALL present a word pushed in cycle N on out_* in cycle N+1 when queue was empty (1-cycle latency); no same-cycle bypass.
- REQ-025 SHALL allow simultaneous push and pop when 0 < count < DEPTH, count unchanged; when full, in_ready=0 even if popping.
- REQ-026 SHALL hold out_* stable while out_valid && !out_ready.
- REQ-027 SHALL, on flush, set count to 0 next cycle, discard the same-cycle pop and ignore in_valid.
- REQ-028 SHALL wrap read/write pointers modulo DEPTH.
- REQ-029 SHALL drive out_* to zero when out_valid=0.

Reset
- REQ-030 SHALL on rst asynchronously clear pointers and count; out_valid=0, in_ready=0 while rst high, 1 the first cycle after release.
- REQ-031 SHALL discard any in-flight handshake when rst asserts mid-operation; storage contents need not be cleared.

Configuration
- REQ-032 SHALL, with ID_I_BUF_CP0_EN defined, decode opcode 0x10: rs=0 MFC0, rs=4 MTC0, in_code[25]=1 with funct 0x02 TLBWI, 0x08 TLBP, 0x18 ERET, 0x20 WAIT, else INST_INVALID.
- REQ-033 SHALL, without ID_I_BUF_CP0_EN, decode opcode 0x10 as INST_INVALID.

Verification
- REQ-034 SHALL push 0x3421FFFF pc 0x100 -> next cycle ORI, rs=1, rt=1, out_imm=0x0000FFFF, out_pc=0x100.
- REQ-035 SHALL push 0x2402FFFC, 0x3C011234, 0x1000FFFF back-to-back, out_ready=1 -> ADDIU imm 0xFFFFFFFC; LUI 0x12340000; BEQ imm 0xFFFFFFFC, out_is_branch=1.
- REQ-036 SHALL push 5 words with out_ready=0, DEPTH=4 -> count=4, in_ready=0, 5th not accepted; then pop all in order.
- REQ-037 SHALL push 0x04110003 then assert flush with in_valid=1 -> count=0, out_valid=0 next cycle, flush-cycle word dropped.
- REQ-038 SHALL push 0x42000018 -> ERET with ID_I_BUF_CP0_EN, INST_INVALID without; 0xFC000000 -> INST_INVALID in both.
- REQ-039 SHALL assert rst with count=3 -> out_valid=0 immediately; after release count=0, in_ready=1.
